// File: rtl/llc_evict_wb_pkg.sv
// Shared LLC cache types and constants used by the eviction/writeback stage.
// Line state encodings match the rest of the LLC datapath.
package llc_evict_wb_pkg;

    localparam int LLC_WAYS       = 16;
    localparam int LLC_WAY_BITS   = 4;
    localparam int LLC_TAG_BITS   = 16;
    localparam int LLC_SET_BITS   = 10;
    localparam int LINE_BITS      = 128;
    localparam int LLC_STATE_BITS = 2;
    localparam int LLC_ADDR_BITS  = LLC_TAG_BITS + LLC_SET_BITS;

    typedef logic [LLC_WAY_BITS-1:0]   llc_way_t;
    typedef logic [LLC_TAG_BITS-1:0]   llc_tag_t;
    typedef logic [LLC_SET_BITS-1:0]   llc_set_t;
    typedef logic [LINE_BITS-1:0]      line_t;
    typedef logic [LLC_STATE_BITS-1:0] llc_state_t;
    typedef logic [LLC_ADDR_BITS-1:0]  llc_addr_t;

    localparam llc_state_t INVALID = 2'd0;
    localparam llc_state_t VALID   = 2'd1;
    localparam llc_state_t SD      = 2'd2;
    localparam llc_state_t SHARED  = 2'd3;

    // Round-robin successor; the carry out of the top bit is dropped so 15 wraps to 0.
    function automatic llc_way_t next_way(llc_way_t w);
        return w + llc_way_t'(1);
    endfunction

endpackage

// File: rtl/llc_evict_wb.sv
// LLC eviction/writeback stage: writes back dirty victims, invalidates the victim
// way, advances the round-robin pointer and signals completion with wb_done.
module llc_evict_wb
    import llc_evict_wb_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wb_start,
    input  logic                      evict,
    input  logic [LLC_WAY_BITS-1:0]   way,
    input  logic [LLC_SET_BITS-1:0]   set,
    input  logic [LLC_TAG_BITS-1:0]   tags_buf [LLC_WAYS],
    input  logic [LLC_STATE_BITS-1:0] states_buf [LLC_WAYS],
    input  logic [LLC_WAYS-1:0]       dirty_bits_buf,
    input  logic [LINE_BITS-1:0]      lines_buf [LLC_WAYS],
    input  logic [LLC_WAY_BITS-1:0]   evict_way_buf,
    input  logic                      mem_req_ready,
    output logic                      mem_req_valid,
    output logic [LLC_ADDR_BITS-1:0]  mem_req_addr,
    output logic [LINE_BITS-1:0]      mem_req_line,
    output logic                      inval_en,
    output logic [LLC_WAY_BITS-1:0]   inval_way,
    output logic                      evict_way_wr_en,
    output logic [LLC_WAY_BITS-1:0]   evict_way_wr_data,
    output logic                      busy,
    output logic                      wb_done,
    output logic                      needs_recall
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        UPD,
        DONE
    } wb_fsm_t;

    wb_fsm_t   state;
    wb_fsm_t   next_state;

    llc_way_t  way_q;
    llc_addr_t addr_q;
    line_t     line_q;
    logic      recall_q;

    logic      victim_valid;
    logic      victim_dirty;
    logic      unused_evict_ptr;

    assign victim_valid     = (states_buf[way] == VALID);
    assign victim_dirty     = dirty_bits_buf[way];
    // The pointer is owned by the lookup stage; it is only observed here.
    assign unused_evict_ptr = ^evict_way_buf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Victim snapshot is taken only on acceptance so later buffer updates cannot disturb it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            way_q    <= '0;
            addr_q   <= '0;
            line_q   <= '0;
            recall_q <= 1'b0;
        end else if (state == IDLE && wb_start) begin
            way_q    <= way;
            addr_q   <= {tags_buf[way], set};
            line_q   <= lines_buf[way];
            recall_q <= evict && !victim_valid;
        end
    end

    always_comb begin
        next_state        = state;
        mem_req_valid     = 1'b0;
        inval_en          = 1'b0;
        evict_way_wr_en   = 1'b0;
        evict_way_wr_data = '0;
        wb_done           = 1'b0;
        needs_recall      = 1'b0;
        case (state)
            IDLE: begin
                if (wb_start) begin
                    if (!evict || !victim_valid) begin
                        next_state = DONE;
                    end else if (victim_dirty) begin
                        next_state = REQ;
                    end else begin
                        next_state = UPD;
                    end
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    next_state = UPD;
                end
            end
            UPD: begin
                inval_en          = 1'b1;
                evict_way_wr_en   = 1'b1;
                evict_way_wr_data = next_way(way_q);
                wb_done           = 1'b1;
                next_state        = IDLE;
            end
            DONE: begin
                wb_done      = 1'b1;
                needs_recall = recall_q;
                next_state   = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign mem_req_addr = addr_q;
    assign mem_req_line = line_q;
    assign inval_way    = way_q;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_llc_evict_wb.sv
// Randomized self-checking bench for llc_evict_wb; expected behaviour is derived
// per transaction from the victim's evict/state/dirty classification.
module tb_llc_evict_wb;
    import llc_evict_wb_pkg::*;

    logic                      clk;
    logic                      rst;
    logic                      wb_start;
    logic                      evict;
    logic [LLC_WAY_BITS-1:0]   way;
    logic [LLC_SET_BITS-1:0]   set;
    logic [LLC_TAG_BITS-1:0]   tags_buf [LLC_WAYS];
    logic [LLC_STATE_BITS-1:0] states_buf [LLC_WAYS];
    logic [LLC_WAYS-1:0]       dirty_bits_buf;
    logic [LINE_BITS-1:0]      lines_buf [LLC_WAYS];
    logic [LLC_WAY_BITS-1:0]   evict_way_buf;
    logic                      mem_req_ready;
    logic                      mem_req_valid;
    logic [LLC_ADDR_BITS-1:0]  mem_req_addr;
    logic [LINE_BITS-1:0]      mem_req_line;
    logic                      inval_en;
    logic [LLC_WAY_BITS-1:0]   inval_way;
    logic                      evict_way_wr_en;
    logic [LLC_WAY_BITS-1:0]   evict_way_wr_data;
    logic                      busy;
    logic                      wb_done;
    logic                      needs_recall;

    int tests_run;
    int tests_failed;

    llc_evict_wb dut (
        .clk               (clk),
        .rst               (rst),
        .wb_start          (wb_start),
        .evict             (evict),
        .way               (way),
        .set               (set),
        .tags_buf          (tags_buf),
        .states_buf        (states_buf),
        .dirty_bits_buf    (dirty_bits_buf),
        .lines_buf         (lines_buf),
        .evict_way_buf     (evict_way_buf),
        .mem_req_ready     (mem_req_ready),
        .mem_req_valid     (mem_req_valid),
        .mem_req_addr      (mem_req_addr),
        .mem_req_line      (mem_req_line),
        .inval_en          (inval_en),
        .inval_way         (inval_way),
        .evict_way_wr_en   (evict_way_wr_en),
        .evict_way_wr_data (evict_way_wr_data),
        .busy              (busy),
        .wb_done           (wb_done),
        .needs_recall      (needs_recall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic scramble();
        for (int i = 0; i < LLC_WAYS; i++) begin
            tags_buf[i]   = LLC_TAG_BITS'($urandom);
            states_buf[i] = LLC_STATE_BITS'($urandom);
            lines_buf[i]  = {$urandom, $urandom, $urandom, $urandom};
        end
        dirty_bits_buf = LLC_WAYS'($urandom);
        evict_way_buf  = LLC_WAY_BITS'($urandom);
        set            = LLC_SET_BITS'($urandom);
    endtask

    // One lookup result: k is the cycle (relative to wb_start) on which ready first rises.
    task automatic applyStimulus(
        input logic       ev,
        input llc_state_t st,
        input logic       dt,
        input llc_way_t   w,
        input llc_tag_t   tg,
        input llc_set_t   st_set,
        input line_t      ln,
        input int         k,
        input logic       inject
    );
        logic      do_wb;
        logic      do_clean;
        logic      recall;
        int        done_cyc;
        llc_addr_t exp_addr;
        llc_way_t  exp_ptr;
        logic      exp_valid;
        logic      exp_done;
        logic      exp_upd;

        @(negedge clk);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_valid", mem_req_valid, 0);
        checkOutput("idle_done", wb_done, 0);

        do_wb    = ev && (st == VALID) && dt;
        do_clean = ev && (st == VALID) && !dt;
        recall   = ev && (st != VALID);
        done_cyc = do_wb ? k + 1 : 1;
        exp_addr = {tg, st_set};
        exp_ptr  = llc_way_t'((int'(w) + 1) % LLC_WAYS);

        scramble();
        evict              = ev;
        way                = w;
        set                = st_set;
        tags_buf[w]        = tg;
        states_buf[w]      = st;
        dirty_bits_buf[w]  = dt;
        lines_buf[w]       = ln;
        mem_req_ready      = 1'($urandom);
        wb_start           = 1'b1;

        for (int j = 1; j <= done_cyc; j++) begin
            @(negedge clk);
            exp_valid = do_wb && (j <= k);
            exp_done  = (j == done_cyc);
            exp_upd   = exp_done && (do_wb || do_clean);
            checkOutput("busy", busy, 1);
            checkOutput("mem_req_valid", mem_req_valid, exp_valid);
            checkOutput("wb_done", wb_done, exp_done);
            checkOutput("needs_recall", needs_recall, exp_done && recall);
            checkOutput("inval_en", inval_en, exp_upd);
            checkOutput("evict_way_wr_en", evict_way_wr_en, exp_upd);
            if (exp_valid) begin
                checkOutput("mem_req_addr", mem_req_addr, exp_addr);
                checkOutput("mem_req_line", mem_req_line, ln);
            end
            if (exp_upd) begin
                checkOutput("inval_way", inval_way, w);
                checkOutput("evict_way_wr_data", evict_way_wr_data, exp_ptr);
            end else begin
                checkOutput("evict_way_wr_data_idle", evict_way_wr_data, 0);
            end
            scramble();
            evict    = 1'($urandom);
            way      = LLC_WAY_BITS'($urandom);
            wb_start = inject && (j == 1);
            if (do_wb && j < k) begin
                mem_req_ready = 1'b0;
            end else if (do_wb && j == k) begin
                mem_req_ready = 1'b1;
            end else begin
                mem_req_ready = 1'($urandom);
            end
        end
        wb_start = 1'b0;
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        rst            = 1'b0;
        wb_start       = 1'b0;
        evict          = 1'b0;
        way            = '0;
        mem_req_ready  = 1'b0;
        scramble();

        #12;
        checkOutput("rst_valid", mem_req_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", wb_done, 0);
        checkOutput("rst_recall", needs_recall, 0);
        checkOutput("rst_inval_en", inval_en, 0);
        checkOutput("rst_inval_way", inval_way, 0);
        checkOutput("rst_wr_en", evict_way_wr_en, 0);
        checkOutput("rst_wr_data", evict_way_wr_data, 0);
        checkOutput("rst_addr", mem_req_addr, 0);
        checkOutput("rst_line", mem_req_line, 0);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(1'b0, VALID, 1'b1, 4'd3, 16'hBEEF, 10'h011, {4{32'h0BAD_F00D}}, 1, 1'b0);
        applyStimulus(1'b1, VALID, 1'b0, 4'd5, 16'h5555, 10'h155, {4{32'h1111_2222}}, 1, 1'b0);
        applyStimulus(1'b1, VALID, 1'b1, 4'd15, 16'h1234, 10'h02A, {4{32'hCAFE_BABE}}, 4, 1'b0);
        applyStimulus(1'b1, SD, 1'b1, 4'd7, 16'h7777, 10'h3FF, {4{32'h7777_0000}}, 1, 1'b0);
        applyStimulus(1'b1, VALID, 1'b1, 4'd2, 16'hA5A5, 10'h100, {4{32'h2468_ACE0}}, 3, 1'b1);
        applyStimulus(1'b1, VALID, 1'b1, 4'd0, 16'h0F0F, 10'h001, {4{32'h1357_9BDF}}, 1, 1'b0);

        // Abandon a writeback by asserting reset while the request is outstanding.
        @(negedge clk);
        scramble();
        evict             = 1'b1;
        way               = 4'd9;
        states_buf[9]     = VALID;
        dirty_bits_buf[9] = 1'b1;
        mem_req_ready     = 1'b0;
        wb_start          = 1'b1;
        @(negedge clk);
        wb_start = 1'b0;
        checkOutput("pre_rst_valid", mem_req_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_valid", mem_req_valid, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_done", wb_done, 0);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(1'b1, VALID, 1'b1, 4'd9, 16'h9999, 10'h099, {4{32'h9999_AAAA}}, 2, 1'b0);

        for (int n = 0; n < 200; n++) begin
            logic       r_ev;
            llc_state_t r_st;
            r_ev = ($urandom_range(0, 3) != 0);
            r_st = ($urandom_range(0, 2) == 0) ? LLC_STATE_BITS'($urandom) : VALID;
            applyStimulus(r_ev, r_st, 1'($urandom), LLC_WAY_BITS'($urandom),
                          LLC_TAG_BITS'($urandom), LLC_SET_BITS'($urandom),
                          {$urandom, $urandom, $urandom, $urandom},
                          $urandom_range(1, 6), ($urandom_range(0, 3) == 0));
        end

        @(negedge clk);
        checkOutput("final_busy", busy, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
